// File: rtl/irq_controller.sv
// irq_controller: edge-latched, maskable, fixed-priority interrupt source for the CPU decoder,
// with a request/take/service handshake keyed off the kernel-mode bit and a small register bus.
module irq_controller #(
    parameter int          NSRC = 4,
    parameter logic [31:0] BASE = 32'h40000024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            pc_kernel,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    input  logic            MemWr,
    input  logic            MemRd,
    output logic [31:0]     rdata,
    output logic            IRQ,
    output logic            in_service
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          r_state;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_src_d;
    logic [3:0]      r_cause;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_clr;
    logic [3:0]      w_win;
    logic            w_elig;
    logic            w_wr_pend;
    logic            w_wr_mask;
    logic            w_unused;

    assign w_rise    = src & ~r_src_d;
    assign w_wr_pend = MemWr && (addr == BASE);
    assign w_wr_mask = MemWr && (addr == BASE + 32'd4);
    assign w_clr     = w_wr_pend ? wdata[NSRC-1:0] : '0;
    assign w_elig    = |(r_pend & r_mask);
    assign w_unused  = &{1'b0, wdata};

    // Scan from the top down so the lowest enabled index wins.
    always_comb begin
        w_win = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (r_pend[i] && r_mask[i]) w_win = 4'(i);
    end

    assign rdata = !MemRd                   ? 32'd0 :
                   addr == BASE             ? 32'(r_pend) :
                   addr == BASE + 32'd4     ? 32'(r_mask) :
                   addr == BASE + 32'd8     ? {26'd0, in_service, 1'b0, r_cause} :
                                              32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pend     <= '0;
            r_mask     <= '0;
            r_src_d    <= '0;
            r_cause    <= 4'd0;
            IRQ        <= 1'b0;
            in_service <= 1'b0;
        end else begin
            r_src_d <= src;
            r_pend  <= (r_pend & ~w_clr) | w_rise;
            if (w_wr_mask) r_mask <= wdata[NSRC-1:0];
            case (r_state)
                IDLE: begin
                    if (w_elig && !pc_kernel) begin
                        r_state <= REQ;
                        IRQ     <= 1'b1;
                    end
                end
                REQ: begin
                    if (pc_kernel) begin
                        r_state    <= SERVICE;
                        IRQ        <= 1'b0;
                        in_service <= 1'b1;
                        r_cause    <= w_win;
                    end else if (!w_elig) begin
                        r_state <= IDLE;
                        IRQ     <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (!pc_kernel) begin
                        r_state    <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    IRQ        <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed vectors; expectations queued by the stimulus, checked by a negedge monitor.
module tb_irq_controller;
    localparam logic [31:0] IPEND  = 32'h40000024;
    localparam logic [31:0] IMASK  = 32'h40000028;
    localparam logic [31:0] ICAUSE = 32'h4000002C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  src = '0;
    logic        pc_kernel = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        MemWr = 1'b0;
    logic        MemRd = 1'b0;
    logic [31:0] rdata;
    logic        IRQ;
    logic        in_service;

    typedef struct {
        int          k;
        logic [31:0] v;
        string       n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    irq_controller #(.NSRC(4), .BASE(32'h40000024)) dut (
        .clk(clk), .reset(reset), .src(src), .pc_kernel(pc_kernel),
        .addr(addr), .wdata(wdata), .MemWr(MemWr), .MemRd(MemRd),
        .rdata(rdata), .IRQ(IRQ), .in_service(in_service)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] got;
            e = q.pop_front();
            got = (e.k == 0) ? rdata : (e.k == 1) ? {31'd0, IRQ} : {31'd0, in_service};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.n, got, e.v);
            end
        end
    end

    task automatic push(input int k, input logic [31:0] v, input string n);
        exp_t e;
        e.k = k;
        e.v = v;
        e.n = n;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        MemRd = 1'b0;
        MemWr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] v, input string n);
        addr  = a;
        MemRd = 1'b1;
        push(0, v, n);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        MemWr = 1'b1;
    endtask

    initial begin
        tick(); tick();
        push(1, 0, "reset_irq");
        push(2, 0, "reset_in_service");
        rd(IPEND, 0, "reset_ipend");
        tick();
        reset = 1'b1;
        tick();

        // single source: mask bit 1, one-cycle pulse
        wr(IMASK, 32'h2); tick();
        src = 4'b0010; tick();
        src = 4'b0000; rd(IPEND, 32'h2, "t1_ipend"); push(1, 0, "t1_irq_early"); tick();
        push(1, 1, "t1_irq_rise"); push(2, 0, "t1_not_service"); pc_kernel = 1'b1; tick();
        push(1, 0, "t1_irq_taken"); push(2, 1, "t1_in_service"); rd(ICAUSE, 32'h21, "t1_icause"); tick();
        wr(IPEND, 32'h2); tick();
        pc_kernel = 1'b0; rd(IPEND, 0, "t1_ipend_cleared"); tick();
        push(2, 0, "t1_returned"); push(1, 0, "t1_no_rereq"); tick();
        push(1, 0, "t1_idle"); tick();

        // priority between sources 3 and 1
        wr(IMASK, 32'hF); tick();
        src = 4'b1010; tick();
        src = 4'b0000; rd(IPEND, 32'hA, "t2_ipend"); tick();
        push(1, 1, "t2_irq"); pc_kernel = 1'b1; tick();
        rd(ICAUSE, 32'h21, "t2_cause1"); tick();
        wr(IPEND, 32'h2); tick();
        pc_kernel = 1'b0; tick();
        push(2, 0, "t2_ret1"); push(1, 0, "t2_irq_ret1"); rd(IPEND, 32'h8, "t2_ipend_left"); tick();
        push(1, 1, "t2_irq2"); pc_kernel = 1'b1; tick();
        rd(ICAUSE, 32'h23, "t2_cause3"); tick();
        wr(IPEND, 32'h8); tick();
        pc_kernel = 1'b0; tick();
        push(2, 0, "t2_ret2"); tick();

        // withdraw by masking while requesting
        src = 4'b0100; tick();
        src = 4'b0000; tick();
        push(1, 1, "t3_irq"); wr(IMASK, 32'h0); tick();
        rd(IPEND, 32'h4, "t3_ipend_kept"); tick();
        push(1, 0, "t3_withdrawn"); push(2, 0, "t3_not_service"); rd(IPEND, 32'h4, "t3_ipend_still"); tick();
        push(1, 0, "t3_stays_idle"); wr(IPEND, 32'h4); tick();

        // set beats clear in the same cycle
        src = 4'b0001; wr(IPEND, 32'h1); tick();
        rd(IPEND, 32'h1, "t4_set_wins"); tick();
        wr(IPEND, 32'h1); tick();
        rd(IPEND, 0, "t4_cleared"); tick();
        src = 4'b0000; tick();

        // a held level sets pending only once
        src = 4'b0100; tick();
        wr(IPEND, 32'h4); tick();
        rd(IPEND, 0, "t4_level_once"); tick();
        src = 4'b0000;

        // bus boundary cases
        wr(IMASK, 32'hFFFF_FFF0); tick();
        rd(IMASK, 0, "t6_mask_upper_ignored"); tick();
        wr(ICAUSE, 32'hFF); tick();
        rd(ICAUSE, 32'h3, "t6_icause_ro"); tick();
        src = 4'b0010; tick();
        src = 4'b0000; addr = IPEND; push(0, 0, "t6_no_rd_strobe"); tick();
        rd(32'h4000_0030, 0, "t6_unmapped"); tick();
        rd(IPEND, 32'h2, "t6_ipend_present"); tick();
        wr(IPEND, 32'h2); tick();

        // kernel mode blocks new requests
        pc_kernel = 1'b1; wr(IMASK, 32'h1); tick();
        src = 4'b0001; tick();
        tick();
        push(1, 0, "t5_blocked_a"); tick();
        push(1, 0, "t5_blocked_b"); tick();
        pc_kernel = 1'b0; push(1, 0, "t5_drop"); tick();
        push(1, 1, "t5_irq_after_drop"); pc_kernel = 1'b1; tick();
        push(2, 1, "t5_service"); tick();

        // asynchronous reset in SERVICE, checked before any further edge
        reset = 1'b0; src = 4'b0000;
        push(1, 0, "t7_irq"); push(2, 0, "t7_in_service"); rd(ICAUSE, 0, "t7_icause");
        tick();
        rd(IPEND, 0, "t7_ipend"); tick();
        rd(IMASK, 0, "t7_imask"); tick();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d left expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
